// File: rtl/ddr4_app_pkg.sv
// Shared MIG app-interface command encodings and the master FSM state type.
package ddr4_app_pkg;

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        WAIT_CAL,
        IDLE,
        WR,
        RD
    } app_state_e;

endpackage

// File: rtl/ddr4_app_master_if.sv
// Request/response stream plus MIG native app handshakes for one DDR4 channel.
// master = the app master block, slave = the requester and MIG side.
interface ddr4_app_master_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 512,
    parameter int MASK_W = DATA_W / 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    logic              app_en;
    logic              app_rdy;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_hi_pri;
    logic              app_wdf_wren;
    logic              app_wdf_rdy;
    logic [DATA_W-1:0] app_wdf_data;
    logic [MASK_W-1:0] app_wdf_mask;
    logic              app_wdf_end;
    logic              app_rd_data_valid;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_correct_en_i;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, req_wmask,
        output req_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output app_en, app_cmd, app_addr, app_hi_pri,
        output app_wdf_wren, app_wdf_data, app_wdf_mask, app_wdf_end,
        output app_correct_en_i,
        input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, req_wmask,
        input  req_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  app_en, app_cmd, app_addr, app_hi_pri,
        input  app_wdf_wren, app_wdf_data, app_wdf_mask, app_wdf_end,
        input  app_correct_en_i,
        output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data
    );

endinterface

// File: rtl/ddr4_rd_rsp_fifo.sv
// First-word-fall-through FIFO holding returned read beats until the requester pops them.
module ddr4_rd_rsp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Head reads as zero when empty so the response bus stays quiet between beats.
    assign pop_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop_ok)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/ddr4_app_master.sv
// DDR4 MIG app-interface initiator: request stream -> MIG command/write-data, in-order read data.
// Build option DDR4_ECC_CNT_EN enables the saturating ECC event counters (otherwise they read 0).
module ddr4_app_master
    import ddr4_app_pkg::*;
#(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 512,
    parameter int MASK_W     = DATA_W / 8,
    parameter int RD_CREDITS = 16,
    parameter int ECC_CNT_W  = 16
) (
    input  logic                          ddr4_ui_clk,
    input  logic                          ddr4_ui_rst_n,
    input  logic                          init_calib_complete,
    ddr4_app_master_if.master             app,
    output logic [$clog2(RD_CREDITS):0]   rd_inflight,
    output logic                          err_rsp_ovf,
    output logic [ECC_CNT_W-1:0]          ecc_single_cnt,
    output logic [ECC_CNT_W-1:0]          ecc_multi_cnt,
    input  logic                          ecc_single,
    input  logic                          ecc_multiple
);
    localparam int CRED_W = $clog2(RD_CREDITS) + 1;

    app_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              cmd_done_q, cmd_done_d;
    logic              wdf_done_q, wdf_done_d;
    logic [CRED_W-1:0] credits_q, inflight_q;
    logic              ovf_q;

    logic              req_ready, app_en, wdf_wren, load;
    logic [2:0]        app_cmd;
    logic              rd_fire, rsp_pop, rsp_valid, fifo_full, fifo_empty;
    logic [DATA_W-1:0] rsp_data;

    always_comb begin
        state_d    = state_q;
        cmd_done_d = cmd_done_q;
        wdf_done_d = wdf_done_q;
        req_ready  = 1'b0;
        app_en     = 1'b0;
        wdf_wren   = 1'b0;
        app_cmd    = APP_CMD_WR;
        load       = 1'b0;
        case (state_q)
            WAIT_CAL: if (init_calib_complete) state_d = IDLE;
            IDLE: begin
                req_ready = (credits_q != '0) && init_calib_complete;
                if (!init_calib_complete) begin
                    state_d = WAIT_CAL;
                end else if (app.req_valid && req_ready) begin
                    load    = 1'b1;
                    state_d = app.req_wr ? WR : RD;
                end
            end
            RD: begin
                app_en  = 1'b1;
                app_cmd = APP_CMD_RD;
                if (app.app_rdy) state_d = IDLE;
            end
            WR: begin
                // Command and data sides finish independently; leave once both have been taken.
                app_en     = !cmd_done_q;
                wdf_wren   = !wdf_done_q;
                cmd_done_d = cmd_done_q || app.app_rdy;
                wdf_done_d = wdf_done_q || app.app_wdf_rdy;
                if (cmd_done_d && wdf_done_d) begin
                    state_d    = IDLE;
                    cmd_done_d = 1'b0;
                    wdf_done_d = 1'b0;
                end
            end
            default: state_d = WAIT_CAL;
        endcase
    end

    assign rd_fire = app_en && app.app_rdy && (app_cmd == APP_CMD_RD);
    assign rsp_pop = rsp_valid && app.rsp_ready;

    always_ff @(posedge ddr4_ui_clk or negedge ddr4_ui_rst_n) begin
        if (!ddr4_ui_rst_n) begin
            state_q    <= WAIT_CAL;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            cmd_done_q <= 1'b0;
            wdf_done_q <= 1'b0;
            credits_q  <= CRED_W'(RD_CREDITS);
            inflight_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_done_q <= cmd_done_d;
            wdf_done_q <= wdf_done_d;
            if (load) begin
                addr_q  <= app.req_addr;
                wdata_q <= app.req_wdata;
                wmask_q <= app.req_wmask;
            end
            case ({rd_fire, rsp_pop})
                2'b10:   credits_q <= credits_q - CRED_W'(1);
                2'b01:   credits_q <= credits_q + CRED_W'(1);
                default: ;
            endcase
            case ({rd_fire, app.app_rd_data_valid})
                2'b10:   inflight_q <= inflight_q + CRED_W'(1);
                2'b01:   inflight_q <= inflight_q - CRED_W'(1);
                default: ;
            endcase
            if (app.app_rd_data_valid && fifo_full) ovf_q <= 1'b1;
        end
    end

    ddr4_rd_rsp_fifo #(
        .DEPTH (RD_CREDITS),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk         (ddr4_ui_clk),
        .rst_n       (ddr4_ui_rst_n),
        .push_i      (app.app_rd_data_valid),
        .push_data_i (app.app_rd_data),
        .pop_i       (rsp_pop),
        .pop_data_o  (rsp_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rsp_valid            = !fifo_empty;
    assign app.rsp_valid        = rsp_valid;
    assign app.rsp_data         = rsp_data;
    assign app.req_ready        = req_ready;
    assign app.app_en           = app_en;
    assign app.app_cmd          = app_cmd;
    assign app.app_addr         = addr_q;
    assign app.app_hi_pri       = 1'b0;
    assign app.app_wdf_wren     = wdf_wren;
    assign app.app_wdf_end      = wdf_wren;
    assign app.app_wdf_data     = wdata_q;
    assign app.app_wdf_mask     = wmask_q;
    assign app.app_correct_en_i = 1'b1;
    assign rd_inflight          = inflight_q;
    assign err_rsp_ovf          = ovf_q;

`ifdef DDR4_ECC_CNT_EN
    logic [ECC_CNT_W-1:0] ecc_s_q, ecc_m_q;

    always_ff @(posedge ddr4_ui_clk or negedge ddr4_ui_rst_n) begin
        if (!ddr4_ui_rst_n) begin
            ecc_s_q <= '0;
            ecc_m_q <= '0;
        end else begin
            if (ecc_single && (ecc_s_q != '1))   ecc_s_q <= ecc_s_q + ECC_CNT_W'(1);
            if (ecc_multiple && (ecc_m_q != '1)) ecc_m_q <= ecc_m_q + ECC_CNT_W'(1);
        end
    end

    assign ecc_single_cnt = ecc_s_q;
    assign ecc_multi_cnt  = ecc_m_q;
`else
    logic unused_ecc;
    assign unused_ecc     = ecc_single | ecc_multiple;
    assign ecc_single_cnt = '0;
    assign ecc_multi_cnt  = '0;
`endif

endmodule

// File: tb/tb_ddr4_app_master.sv
// Directed bench for ddr4_app_master with a 4-deep response FIFO and 4-bit ECC counters.
module tb_ddr4_app_master;
    localparam int ADDR_W = 28, DATA_W = 512, MASK_W = 64, RD_CREDITS = 4, ECC_CNT_W = 4;

    logic clk = 1'b0, rst_n = 1'b0, calib = 1'b0, ecc_s = 1'b0, ecc_m = 1'b0;
    logic [2:0] rd_inflight;
    logic err;
    logic [ECC_CNT_W-1:0] ecc_s_cnt, ecc_m_cnt;
    int n_cmp = 0, n_bad = 0;

    ddr4_app_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) ifc ();

    ddr4_app_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
        .RD_CREDITS(RD_CREDITS), .ECC_CNT_W(ECC_CNT_W)
    ) dut (
        .ddr4_ui_clk(clk), .ddr4_ui_rst_n(rst_n), .init_calib_complete(calib),
        .app(ifc), .rd_inflight(rd_inflight), .err_rsp_ovf(err),
        .ecc_single_cnt(ecc_s_cnt), .ecc_multi_cnt(ecc_m_cnt),
        .ecc_single(ecc_s), .ecc_multiple(ecc_m)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] beat(input int k);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(k);
        return {16{w}};
    endfunction

    // Present one read, wait (bounded) for acceptance, then let the command issue with app_rdy=1.
    task automatic issue_read(input logic [ADDR_W-1:0] a);
        ifc.req_valid = 1'b1; ifc.req_wr = 1'b0; ifc.req_addr = a; ifc.app_rdy = 1'b1;
        for (int w = 0; w < 20 && !ifc.req_ready; w++) tick();
        n_cmp++; if (ifc.req_ready !== 1'b1) begin n_bad++; $display("FAIL issue_ready: got %0b want 1", ifc.req_ready); end
        tick();
        ifc.req_valid = 1'b0;
        n_cmp++; if (ifc.app_en !== 1'b1 || ifc.app_cmd !== 3'b001 || ifc.app_addr !== a) begin
            n_bad++; $display("FAIL issue_cmd: got en=%0b cmd=%0h addr=%0h want en=1 cmd=1 addr=%0h", ifc.app_en, ifc.app_cmd, ifc.app_addr, a);
        end
        tick();
    endtask

    task automatic ret_beat(input int k);
        ifc.app_rd_data_valid = 1'b1; ifc.app_rd_data = beat(k);
        tick();
        ifc.app_rd_data_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (ifc.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %0b want 0", ifc.req_ready); end
        n_cmp++; if (ifc.app_en !== 1'b0 || ifc.app_wdf_wren !== 1'b0 || ifc.app_wdf_end !== 1'b0) begin
            n_bad++; $display("FAIL rst_enables: got en=%0b wren=%0b end=%0b want 0", ifc.app_en, ifc.app_wdf_wren, ifc.app_wdf_end); end
        n_cmp++; if (ifc.app_cmd !== 3'b000 || ifc.app_addr !== '0 || ifc.app_hi_pri !== 1'b0) begin
            n_bad++; $display("FAIL rst_cmd: got cmd=%0h addr=%0h hi=%0b want 0", ifc.app_cmd, ifc.app_addr, ifc.app_hi_pri); end
        n_cmp++; if (ifc.app_correct_en_i !== 1'b1) begin n_bad++; $display("FAIL rst_correct_en: got %0b want 1", ifc.app_correct_en_i); end
        n_cmp++; if (ifc.rsp_valid !== 1'b0 || ifc.rsp_data !== '0) begin n_bad++; $display("FAIL rst_rsp: got valid=%0b want 0", ifc.rsp_valid); end
        n_cmp++; if (rd_inflight !== 3'd0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_counters: got infl=%0d err=%0b want 0", rd_inflight, err); end
        n_cmp++; if (ecc_s_cnt !== '0 || ecc_m_cnt !== '0) begin n_bad++; $display("FAIL rst_ecc: got %0d/%0d want 0/0", ecc_s_cnt, ecc_m_cnt); end
        n_cmp++; if (ifc.app_wdf_data !== '0 || ifc.app_wdf_mask !== '0) begin n_bad++; $display("FAIL rst_wdf: got mask=%0h want 0", ifc.app_wdf_mask); end
    endtask

    task automatic test_calib();
        rst_n = 1'b1;
        ifc.req_valid = 1'b1; ifc.req_wr = 1'b0; ifc.req_addr = 28'h77;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_cmp++; if (ifc.req_ready !== 1'b0 || ifc.app_en !== 1'b0) begin
                n_bad++; $display("FAIL calib_gate[%0d]: got ready=%0b en=%0b want 0/0", i, ifc.req_ready, ifc.app_en); end
        end
        calib = 1'b1; ifc.req_valid = 1'b0;
        n_cmp++; if (ifc.req_ready !== 1'b0) begin n_bad++; $display("FAIL calib_same_cycle: got %0b want 0", ifc.req_ready); end
        tick();
        n_cmp++; if (ifc.req_ready !== 1'b1) begin n_bad++; $display("FAIL calib_ready: got %0b want 1", ifc.req_ready); end
    endtask

    task automatic test_write();
        logic [DATA_W-1:0] d;
        d = {64{8'hA5}};
        ifc.req_valid = 1'b1; ifc.req_wr = 1'b1; ifc.req_addr = 28'h100; ifc.req_wdata = d; ifc.req_wmask = '0;
        ifc.app_rdy = 1'b1; ifc.app_wdf_rdy = 1'b0;
        n_cmp++; if (ifc.req_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready: got %0b want 1", ifc.req_ready); end
        tick();
        ifc.req_valid = 1'b0;
        n_cmp++; if (ifc.app_cmd !== 3'b000 || ifc.app_addr !== 28'h100 || ifc.app_wdf_data !== d || ifc.app_wdf_mask !== '0) begin
            n_bad++; $display("FAIL wr_cmd: got cmd=%0h addr=%0h mask=%0h want 0/100/0", ifc.app_cmd, ifc.app_addr, ifc.app_wdf_mask); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (ifc.app_wdf_wren !== 1'b1 || ifc.app_wdf_end !== ifc.app_wdf_wren) begin
                n_bad++; $display("FAIL wr_wren[%0d]: got wren=%0b end=%0b want 1/1", i, ifc.app_wdf_wren, ifc.app_wdf_end); end
            n_cmp++; if (ifc.app_en !== (i == 0)) begin
                n_bad++; $display("FAIL wr_en[%0d]: got %0b want %0b", i, ifc.app_en, (i == 0)); end
            ifc.app_wdf_rdy = (i == 5);
            tick();
        end
        ifc.app_wdf_rdy = 1'b0;
        n_cmp++; if (ifc.app_wdf_wren !== 1'b0 || ifc.app_en !== 1'b0 || ifc.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL wr_done: got wren=%0b en=%0b ready=%0b want 0/0/1", ifc.app_wdf_wren, ifc.app_en, ifc.req_ready); end
    endtask

    task automatic test_rd_stall();
        ifc.req_valid = 1'b1; ifc.req_wr = 1'b0; ifc.req_addr = 28'h2A; ifc.app_rdy = 1'b0;
        tick();
        ifc.req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (ifc.app_en !== 1'b1 || ifc.app_cmd !== 3'b001 || ifc.app_addr !== 28'h2A) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got en=%0b cmd=%0h addr=%0h want 1/1/2a", i, ifc.app_en, ifc.app_cmd, ifc.app_addr); end
            tick();
        end
        ifc.app_rdy = 1'b1;
        n_cmp++; if (ifc.app_en !== 1'b1) begin n_bad++; $display("FAIL stall_c11: got %0b want 1", ifc.app_en); end
        tick();
        n_cmp++; if (ifc.app_en !== 1'b0 || rd_inflight !== 3'd1) begin
            n_bad++; $display("FAIL stall_accept: got en=%0b infl=%0d want 0/1", ifc.app_en, rd_inflight); end
        ret_beat(42);
        n_cmp++; if (ifc.rsp_valid !== 1'b1 || ifc.rsp_data !== beat(42) || rd_inflight !== 3'd0) begin
            n_bad++; $display("FAIL stall_rsp: got v=%0b infl=%0d data=%0h want 1/0/%0h", ifc.rsp_valid, rd_inflight, ifc.rsp_data, beat(42)); end
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;
        n_cmp++; if (ifc.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL stall_pop: got %0b want 0", ifc.rsp_valid); end
    endtask

    task automatic test_credits();
        for (int i = 0; i < 4; i++) issue_read(ADDR_W'(i));
        ifc.req_valid = 1'b1; ifc.req_wr = 1'b0; ifc.req_addr = 28'd4;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (ifc.req_ready !== 1'b0 || ifc.app_en !== 1'b0) begin
                n_bad++; $display("FAIL cred_block[%0d]: got ready=%0b en=%0b want 0/0", i, ifc.req_ready, ifc.app_en); end
            tick();
        end
        ifc.req_valid = 1'b0;
        n_cmp++; if (rd_inflight !== 3'd4) begin n_bad++; $display("FAIL cred_inflight: got %0d want 4", rd_inflight); end
        for (int k = 0; k < 4; k++) ret_beat(k);
        n_cmp++; if (rd_inflight !== 3'd0 || err !== 1'b0 || ifc.rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL cred_returned: got infl=%0d err=%0b v=%0b want 0/0/1", rd_inflight, err, ifc.rsp_valid); end
        ifc.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (ifc.rsp_valid !== 1'b1 || ifc.rsp_data !== beat(k)) begin
                n_bad++; $display("FAIL cred_order[%0d]: got v=%0b data=%0h want 1/%0h", k, ifc.rsp_valid, ifc.rsp_data, beat(k)); end
            tick();
        end
        ifc.rsp_ready = 1'b0;
        n_cmp++; if (ifc.rsp_valid !== 1'b0 || ifc.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL cred_drained: got v=%0b ready=%0b want 0/1", ifc.rsp_valid, ifc.req_ready); end
        issue_read(28'd4);
        issue_read(28'd5);
        n_cmp++; if (rd_inflight !== 3'd2) begin n_bad++; $display("FAIL cred_rest: got %0d want 2", rd_inflight); end
        ret_beat(4);
        ret_beat(5);
        ifc.rsp_ready = 1'b1;
        for (int k = 4; k < 6; k++) begin
            n_cmp++; if (ifc.rsp_data !== beat(k)) begin n_bad++; $display("FAIL cred_rest_data[%0d]: got %0h want %0h", k, ifc.rsp_data, beat(k)); end
            tick();
        end
        ifc.rsp_ready = 1'b0;
    endtask

    task automatic test_same_cycle();
        for (int i = 0; i < 3; i++) issue_read(ADDR_W'(28'h50 + i));
        ret_beat(80);
        ifc.req_valid = 1'b1; ifc.req_wr = 1'b0; ifc.req_addr = 28'h55;
        n_cmp++; if (ifc.req_ready !== 1'b1 || rd_inflight !== 3'd2) begin
            n_bad++; $display("FAIL same_pre: got ready=%0b infl=%0d want 1/2", ifc.req_ready, rd_inflight); end
        tick();
        ifc.req_valid = 1'b0; ifc.rsp_ready = 1'b1;
        n_cmp++; if (ifc.app_en !== 1'b1 || ifc.rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL same_both: got en=%0b v=%0b want 1/1", ifc.app_en, ifc.rsp_valid); end
        tick();
        ifc.rsp_ready = 1'b0;
        n_cmp++; if (rd_inflight !== 3'd3 || ifc.rsp_valid !== 1'b0 || ifc.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL same_post: got infl=%0d v=%0b ready=%0b want 3/0/1", rd_inflight, ifc.rsp_valid, ifc.req_ready); end
        issue_read(28'h56);
        n_cmp++; if (ifc.req_ready !== 1'b0) begin n_bad++; $display("FAIL same_last_credit: got %0b want 0", ifc.req_ready); end
        for (int k = 0; k < 4; k++) ret_beat(90 + k);
        ifc.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        ifc.rsp_ready = 1'b0;
        n_cmp++; if (rd_inflight !== 3'd0 || ifc.rsp_valid !== 1'b0 || ifc.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL same_cleanup: got infl=%0d v=%0b ready=%0b want 0/0/1", rd_inflight, ifc.rsp_valid, ifc.req_ready); end
    endtask

    task automatic test_ecc();
        logic [ECC_CNT_W-1:0] exp_s, exp_m;
`ifdef DDR4_ECC_CNT_EN
        exp_s = 4'd15; exp_m = 4'd2;
`else
        exp_s = 4'd0;  exp_m = 4'd0;
`endif
        for (int i = 0; i < 20; i++) begin
            ecc_s = 1'b1; ecc_m = (i < 2);
            tick();
            ecc_s = 1'b0; ecc_m = 1'b0;
            tick();
        end
        n_cmp++; if (ecc_s_cnt !== exp_s) begin n_bad++; $display("FAIL ecc_single: got %0d want %0d", ecc_s_cnt, exp_s); end
        n_cmp++; if (ecc_m_cnt !== exp_m) begin n_bad++; $display("FAIL ecc_multi: got %0d want %0d", ecc_m_cnt, exp_m); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ovf_early[%0d]: got %0b want 0", k, err); end
            ret_beat(200 + k);
        end
        n_cmp++; if (err !== 1'b1 || ifc.rsp_data !== beat(200)) begin
            n_bad++; $display("FAIL ovf_set: got err=%0b data=%0h want 1/%0h", err, ifc.rsp_data, beat(200)); end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b0 || ifc.rsp_valid !== 1'b0 || rd_inflight !== 3'd0 || ifc.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL midrst: got err=%0b v=%0b infl=%0d ready=%0b want 0/0/0/0", err, ifc.rsp_valid, rd_inflight, ifc.req_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (ifc.req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_recover: got %0b want 1", ifc.req_ready); end
    endtask

    initial begin
        ifc.req_valid = 1'b0; ifc.req_wr = 1'b0; ifc.req_addr = '0; ifc.req_wdata = '0; ifc.req_wmask = '0;
        ifc.rsp_ready = 1'b0; ifc.app_rdy = 1'b0; ifc.app_wdf_rdy = 1'b0;
        ifc.app_rd_data_valid = 1'b0; ifc.app_rd_data = '0;
        test_reset();
        repeat (3) tick();
        test_calib();
        test_write();
        test_rd_stall();
        test_credits();
        test_same_cycle();
        test_ecc();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
